invcipher_round_ctrl: RTL and testbench
=======================================

Name: invcipher_round_ctrl

Overview:
Iterative sequencer for AES inverse-cipher decryption. Accepts one ciphertext block per transaction and drives an external combinational inverse-round datapath one round per clock. Fetches round keys from the key-schedule store in reverse order (w[Nr] down to w[0]) and returns the plaintext over a valid/ready output handshake. Sits between the block-level stream interface and the shared inverse-round datapath / expanded-key RAM.

Parameters:
Nr, 10, number of rounds (10/12/14 for AES-128/192/256); only these values legal
RKAW, 4, round-key address width; must satisfy 2**RKAW > Nr

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext block offered
in_ready  output  1  controller can accept a block
in_data  input  128  ciphertext block
out_valid  output  1  plaintext block available
out_ready  input  1  consumer accepts plaintext
out_data  output  128  plaintext block
flush  input  1  synchronous abort of the current block
busy  output  1  transaction in progress (any state other than IDLE)
rk_addr  output  RKAW  round-key index into the key-schedule store
rk_data  input  128  round key for rk_addr
dp_state  output  128  state presented to the datapath
dp_key  output  128  round key presented to the datapath (rk_data passthrough)
dp_mode  output  2  0 = AddRoundKey only; 1 = middle round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns); 2 = final round (no InvMixColumns); 3 = unused
dp_result  input  128  datapath output for dp_state/dp_key/dp_mode in the same cycle

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low. Reset forces state IDLE, round counter 0, state register 0, out_data 0, out_valid 0, rk_addr 0, dp_mode 0. In IDLE, in_ready=1 and busy=0.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the state register, set rnd=Nr-1, and go to INIT.
- INIT (1 cycle): dp_mode=0, rk_addr=Nr. Register dp_result, then go to ROUND. If Nr-1==0, go to FINAL instead (not reachable with legal Nr).
- ROUND (Nr-1 cycles): dp_mode=1, rk_addr=rnd. Register dp_result each cycle. When rnd==1, go to FINAL; otherwise decrement rnd.
- FINAL (1 cycle): dp_mode=2, rk_addr=0. Register dp_result into out_data, set out_valid=1, and go to DONE.
- DONE: hold out_data and out_valid stable until out_ready, then clear out_valid and return to IDLE. in_ready=0 in DONE, so there is no same-cycle accept.
- dp_state always equals the state register. dp_key always equals rk_data. rk_data is a combinational read valid in the same cycle as rk_addr.
- Latency: an accept in cycle T gives out_valid in cycle T+Nr+2 (12 cycles for Nr=10). Throughput is one block per Nr+3 cycles minimum.
- Outside INIT/ROUND/FINAL: dp_mode=0, rk_addr=0 (don't-care to the datapath, but driven to these values).
- flush: takes priority over every transition. In any state it returns to IDLE next cycle, clears out_valid and rnd, and leaves out_data unchanged. A flush coincident with an in_valid accept in IDLE discards that block.
- Reset asserted mid-transaction: immediate return to reset values. No output is produced for the in-flight block.
- in_data is ignored while in_ready=0. Upstream must hold in_valid/in_data until accepted.

Optional Feature:
INVCIPHER_CTRL_RKREG_EN
- Defined: the key store has a registered read with 1-cycle latency. A PREFETCH state is inserted after IDLE that issues rk_addr=Nr. Every state then presents rk_addr one cycle ahead of its use (INIT issues Nr-1, ROUND issues rnd-1, the last ROUND issues 0). Latency becomes Nr+3 cycles (13 for Nr=10). flush and reset behaviour are unchanged.
- Not defined: combinational key read exactly as described above.

Test Plan:
- FIPS-197 AES-128 vector: key 000102..0f preloaded into the key store, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, with out_valid exactly 12 cycles after accept (13 with INVCIPHER_CTRL_RKREG_EN).
- rk_addr sequence check over that transaction -> 10,9,8,...,1,0 on consecutive cycles; dp_mode sequence 0, then 1 x9, then 2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout; accept occurs one cycle after the out_ready handshake completes.
- Back-to-back: two vectors queued with in_valid held high -> both correct, second accept occurs one cycle after the first output handshake.
- flush asserted during ROUND (rnd=5) -> next cycle IDLE, busy=0, out_valid never asserts; a following block decrypts correctly.
- rst_n pulsed low asynchronously mid-FINAL -> outputs immediately at reset values, in_ready=1 after release; Nr=14 run with the FIPS-197 AES-256 vector (ciphertext 8ea2b7ca516745bfeafc49904b496089) -> plaintext 00112233445566778899aabbccddeeff, 16-cycle latency.

Source files
------------

// File: rtl/invcipher_round_ctrl.sv
// invcipher_round_ctrl
// Iterative AES inverse-cipher sequencer. Takes one ciphertext block over a
// valid/ready input, walks an external combinational inverse-round datapath
// one round per clock with round keys fetched w[Nr] down to w[0], and returns
// the plaintext over a valid/ready output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     ciphertext handshake, in_data = ciphertext block
//   out_valid/out_ready   plaintext handshake, out_data = plaintext block
//   flush                 synchronous abort, returns to IDLE next cycle
//   busy                  high in any state other than IDLE
//   rk_addr/rk_data       round-key store read port
//   dp_state/dp_key/dp_mode -> datapath, dp_result <- datapath (same cycle)
//
// Build option: INVCIPHER_CTRL_RKREG_EN selects a key store with a registered
// read (1-cycle latency). A PREFETCH state is added and every state issues
// rk_addr one cycle ahead of its use; latency grows by one cycle.
module invcipher_round_ctrl #(
    parameter int Nr   = 10,
    parameter int RKAW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    input  logic            flush,
    output logic            busy,
    output logic [RKAW-1:0] rk_addr,
    input  logic [127:0]    rk_data,
    output logic [127:0]    dp_state,
    output logic [127:0]    dp_key,
    output logic [1:0]      dp_mode,
    input  logic [127:0]    dp_result
);

    generate
        if (!(Nr == 10 || Nr == 12 || Nr == 14) || ((2 ** RKAW) <= Nr)) begin : g_param_chk
            $error("invcipher_round_ctrl: Nr must be 10/12/14 and 2**RKAW > Nr");
        end
    endgenerate

    localparam logic [RKAW-1:0] NR_A = RKAW'(Nr);
    localparam logic [RKAW-1:0] ONE  = RKAW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef INVCIPHER_CTRL_RKREG_EN
        S_PREFETCH,
`endif
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [RKAW-1:0] r_rnd, w_rnd_nxt;
    logic [127:0]    r_st;
    logic [127:0]    r_out_data;
    logic            r_out_valid, w_out_valid_nxt;
    logic            w_ld_in, w_ld_st, w_ld_out;

    always_comb begin
        w_next          = r_state;
        w_rnd_nxt       = r_rnd;
        w_out_valid_nxt = r_out_valid;
        w_ld_in         = 1'b0;
        w_ld_st         = 1'b0;
        w_ld_out        = 1'b0;
        in_ready        = 1'b0;
        dp_mode         = 2'd0;
        rk_addr         = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_ld_in   = 1'b1;
                    w_rnd_nxt = NR_A - ONE;
`ifdef INVCIPHER_CTRL_RKREG_EN
                    w_next    = S_PREFETCH;
`else
                    w_next    = S_INIT;
`endif
                end
            end
`ifdef INVCIPHER_CTRL_RKREG_EN
            S_PREFETCH: begin
                rk_addr = NR_A;
                w_next  = S_INIT;
            end
`endif
            S_INIT: begin
                dp_mode = 2'd0;
`ifdef INVCIPHER_CTRL_RKREG_EN
                rk_addr = r_rnd;        // key for the first middle round
`else
                rk_addr = NR_A;
`endif
                w_ld_st = 1'b1;
                w_next  = (Nr == 1) ? S_FINAL : S_ROUND;
            end
            S_ROUND: begin
                dp_mode = 2'd1;
`ifdef INVCIPHER_CTRL_RKREG_EN
                rk_addr = r_rnd - ONE;  // next cycle's key; reaches 0 on the last round
`else
                rk_addr = r_rnd;
`endif
                w_ld_st = 1'b1;
                if (r_rnd == ONE) w_next = S_FINAL;
                else              w_rnd_nxt = r_rnd - ONE;
            end
            S_FINAL: begin
                dp_mode         = 2'd2;
                rk_addr         = '0;
                w_ld_out        = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_next          = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_next          = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // Abort wins over every transition; out_data keeps its last value.
        if (flush) begin
            w_next          = S_IDLE;
            w_rnd_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_ld_in         = 1'b0;
            w_ld_st         = 1'b0;
            w_ld_out        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rnd       <= '0;
            r_st        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rnd       <= w_rnd_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_ld_in)      r_st <= in_data;
            else if (w_ld_st) r_st <= dp_result;
            if (w_ld_out)     r_out_data <= dp_result;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dp_state  = r_st;
    assign dp_key    = rk_data;

endmodule

// File: tb/tb_invcipher_round_ctrl.sv
// Bench for invcipher_round_ctrl: two instances (Nr=10, Nr=14) each driving a
// behavioural AES inverse-round datapath and key store built in the bench.
module tb_invcipher_round_ctrl;

`ifdef INVCIPHER_CTRL_RKREG_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int LAT10 = 10 + 2 + OFF;
    localparam int LAT14 = 14 + 2 + OFF;

    logic clk, rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        if (a == 8'h00) return 8'h00;
        r = 8'h01; p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction
    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c - r + 4) % 4));
        return o;
    endfunction
    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox(gb(s, i));
        return o;
    endfunction
    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
            o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
            o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
            o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
        end
        return o;
    endfunction
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [1:0] m);
        case (m)
            2'd0:    return s ^ k;
            2'd1:    return inv_mix(inv_sub(inv_shift(s)) ^ k);
            2'd2:    return inv_sub(inv_shift(s)) ^ k;
            default: return s;
        endcase
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ---------------- key stores ----------------
    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k < 16; k++) begin
            if (nr == 10) ks10[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
            else          ks14[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
        end
    endtask

    // Reference: FIPS-197 InvCipher loop straight over the expanded keys.
    function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
        logic [127:0] s;
        s = ct ^ ((nr == 10) ? ks10[nr] : ks14[nr]);
        for (int r = nr - 1; r >= 1; r--)
            s = inv_mix(inv_sub(inv_shift(s)) ^ ((nr == 10) ? ks10[r] : ks14[r]));
        return inv_sub(inv_shift(s)) ^ ((nr == 10) ? ks10[0] : ks14[0]);
    endfunction

    // ---------------- DUT Nr=10 ----------------
    logic         in_valid10, in_ready10, out_valid10, out_ready10, flush10, busy10;
    logic [127:0] in_data10, out_data10, rk_data10, dp_state10, dp_key10, dp_res10;
    logic [3:0]   rk_addr10;
    logic [1:0]   dp_mode10;

    invcipher_round_ctrl #(.Nr(10), .RKAW(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_data(in_data10), .out_valid(out_valid10), .out_ready(out_ready10),
        .out_data(out_data10), .flush(flush10), .busy(busy10), .rk_addr(rk_addr10),
        .rk_data(rk_data10), .dp_state(dp_state10), .dp_key(dp_key10),
        .dp_mode(dp_mode10), .dp_result(dp_res10));

    // ---------------- DUT Nr=14 ----------------
    logic         in_valid14, in_ready14, out_valid14, out_ready14, flush14, busy14;
    logic [127:0] in_data14, out_data14, rk_data14, dp_state14, dp_key14, dp_res14;
    logic [3:0]   rk_addr14;
    logic [1:0]   dp_mode14;

    invcipher_round_ctrl #(.Nr(14), .RKAW(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data14), .out_valid(out_valid14), .out_ready(out_ready14),
        .out_data(out_data14), .flush(flush14), .busy(busy14), .rk_addr(rk_addr14),
        .rk_data(rk_data14), .dp_state(dp_state14), .dp_key(dp_key14),
        .dp_mode(dp_mode14), .dp_result(dp_res14));

    assign dp_res10 = inv_round(dp_state10, dp_key10, dp_mode10);
    assign dp_res14 = inv_round(dp_state14, dp_key14, dp_mode14);
`ifdef INVCIPHER_CTRL_RKREG_EN
    always_ff @(posedge clk) begin
        rk_data10 <= ks10[rk_addr10];
        rk_data14 <= ks14[rk_addr14];
    end
`else
    assign rk_data10 = ks10[rk_addr10];
    assign rk_data14 = ks14[rk_addr14];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check/stimulus tasks ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Offer a block to dut10; returns one cycle after the accepting edge.
    task automatic send(input logic [127:0] ct);
        int n;
        in_valid10 = 1'b1; in_data10 = ct; n = 0;
        while (!in_ready10 && n < 50) begin cyc(); n++; end
        chk("accept_wait", 128'(in_ready10), 128'(1));
        cyc();
        in_valid10 = 1'b0;
    endtask

    // Expect the plaintext exactly LAT10 cycles after accept, optional
    // rk_addr/dp_mode sequence check, bp cycles of output backpressure.
    task automatic recv(input string tag, input logic [127:0] exp, input bit seq, input int bp);
        bit early, bsy, stable;
        int j, ea, em;
        early = 1'b0; bsy = 1'b1; stable = 1'b1;
        for (int k = 1; k < LAT10; k++) begin
            if (out_valid10 !== 1'b0) early = 1'b1;
            if (busy10 !== 1'b1) bsy = 1'b0;
            if (seq) begin
                j  = k - OFF;
                em = (j <= 1) ? 0 : (j <= 10) ? 1 : 2;
                if (OFF == 0) ea = 10 - (j - 1);
                else          ea = (j == 0) ? 10 : ((10 - j) > 0 ? 10 - j : 0);
                chk($sformatf("%s_rk_addr_c%0d", tag, k), 128'(rk_addr10), 128'(ea));
                chk($sformatf("%s_dp_mode_c%0d", tag, k), 128'(dp_mode10), 128'(em));
            end
            cyc();
        end
        chk({tag, "_no_early_valid"}, 128'(early), 128'(0));
        chk({tag, "_busy_in_flight"}, 128'(bsy), 128'(1));
        chk({tag, "_out_valid_at_lat"}, 128'(out_valid10), 128'(1));
        chk({tag, "_out_data"}, out_data10, exp);
        chk({tag, "_in_ready_done"}, 128'(in_ready10), 128'(0));
        for (int b = 0; b < bp; b++) begin
            cyc();
            if (!(out_valid10 === 1'b1 && out_data10 === exp && in_ready10 === 1'b0)) stable = 1'b0;
        end
        if (bp > 0) chk({tag, "_backpressure_hold"}, 128'(stable), 128'(1));
        out_ready10 = 1'b1;
        cyc();
        out_ready10 = 1'b0;
        chk({tag, "_valid_cleared"}, 128'(out_valid10), 128'(0));
        chk({tag, "_idle_ready"}, 128'(in_ready10), 128'(1));
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] a, b, last;
        int n;
        bit seen;
        rst_n = 1'b0;
        in_valid10 = 0; in_data10 = '0; out_ready10 = 0; flush10 = 0;
        in_valid14 = 0; in_data14 = '0; out_ready14 = 0; flush14 = 0;
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        #12;
        chk("rst_out_valid", 128'(out_valid10), 128'(0));
        chk("rst_out_data", out_data10, '0);
        chk("rst_busy", 128'(busy10), 128'(0));
        chk("rst_in_ready", 128'(in_ready10), 128'(1));
        chk("rst_rk_addr", 128'(rk_addr10), 128'(0));
        chk("rst_dp_mode", 128'(dp_mode10), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        cyc();

        // FIPS-197 AES-128 vector with sequence check and 5 cycles backpressure
        send(CT128);
        recv("fips128", PT, 1'b1, 5);

        // randomized blocks
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            send(a);
            recv($sformatf("rand%0d", i), ref_dec(a, 10), 1'b0, $urandom_range(0, 3));
        end

        // back-to-back with in_valid held high
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        in_valid10 = 1'b1; in_data10 = a; n = 0;
        while (!in_ready10 && n < 50) begin cyc(); n++; end
        cyc();
        in_data10 = b; out_ready10 = 1'b1; n = 1;
        while (!out_valid10 && n < 40) begin cyc(); n++; end
        chk("b2b_lat1", 128'(n), 128'(LAT10));
        chk("b2b_data1", out_data10, ref_dec(a, 10));
        cyc();
        chk("b2b_gap_ready", 128'(in_ready10), 128'(1));
        chk("b2b_gap_idle", 128'(busy10), 128'(0));
        cyc();
        in_valid10 = 1'b0;
        chk("b2b_second_accept", 128'(busy10), 128'(1));
        n = 1;
        while (!out_valid10 && n < 40) begin cyc(); n++; end
        chk("b2b_lat2", 128'(n), 128'(LAT10));
        chk("b2b_data2", out_data10, ref_dec(b, 10));
        last = ref_dec(b, 10);
        cyc();
        out_ready10 = 1'b0;
        chk("b2b_done", 128'(out_valid10), 128'(0));

        // flush during ROUND with rnd=5
        send({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!(dp_mode10 == 2'd1 && rk_addr10 == 4'(5 - OFF)) && n < 40) begin cyc(); n++; end
        chk("flush_reach_rnd5", 128'(n < 40), 128'(1));
        flush10 = 1'b1;
        cyc();
        flush10 = 1'b0;
        chk("flush_busy", 128'(busy10), 128'(0));
        chk("flush_in_ready", 128'(in_ready10), 128'(1));
        chk("flush_out_data_kept", out_data10, last);
        seen = 1'b0;
        for (int k = 0; k < LAT10 + 2; k++) begin
            if (out_valid10 !== 1'b0) seen = 1'b1;
            cyc();
        end
        chk("flush_no_output", 128'(seen), 128'(0));
        a = {$urandom, $urandom, $urandom, $urandom};
        send(a);
        recv("post_flush", ref_dec(a, 10), 1'b0, 0);

        // asynchronous reset in FINAL
        send(CT128);
        n = 0;
        while (dp_mode10 != 2'd2 && n < 40) begin cyc(); n++; end
        chk("rst_reach_final", 128'(n < 40), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid10), 128'(0));
        chk("arst_out_data", out_data10, '0);
        chk("arst_busy", 128'(busy10), 128'(0));
        chk("arst_rk_addr", 128'(rk_addr10), 128'(0));
        chk("arst_dp_mode", 128'(dp_mode10), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        cyc();
        chk("arst_in_ready", 128'(in_ready10), 128'(1));
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid10 !== 1'b0) seen = 1'b1;
            cyc();
        end
        chk("arst_no_output", 128'(seen), 128'(0));

        // Nr=14: FIPS-197 AES-256 vector then one random block
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? CT256 : {$urandom, $urandom, $urandom, $urandom};
            in_valid14 = 1'b1; in_data14 = a; n = 0;
            while (!in_ready14 && n < 50) begin cyc(); n++; end
            cyc();
            in_valid14 = 1'b0; n = 1;
            while (!out_valid14 && n < 60) begin cyc(); n++; end
            chk($sformatf("nr14_%0d_latency", i), 128'(n), 128'(LAT14));
            chk($sformatf("nr14_%0d_data", i), out_data14, (i == 0) ? PT : ref_dec(a, 14));
            out_ready14 = 1'b1;
            cyc();
            out_ready14 = 1'b0;
            chk($sformatf("nr14_%0d_cleared", i), 128'(out_valid14), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
